// File: rtl/tdc_thrm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tdc_thrm_decoder
// Brief    : Decodes a sampled TDC thermometer word into a phase position, a
//            signed phase error, edge-fault flags and a hysteretic lock flag.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_thrm_decoder #(
  parameter int TDC_BITS   = 64,
  parameter int POS_W      = 7,
  parameter int LOCK_WIN   = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                ref_clk,
  input  logic                rst_n,
  input  logic [TDC_BITS-1:0] sampled_tdc,
  input  logic                tdc_en,
  input  logic [POS_W-1:0]    tdc_offset,
  output logic [POS_W-1:0]    phase_bin,
  output logic [POS_W:0]      phase_err,
  output logic                err_valid,
  output logic                edge_none,
  output logic                edge_multi,
  output logic                lock_det
);

  localparam int C_HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int C_MISS_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  logic [TDC_BITS-1:0] r_t1;
  logic [TDC_BITS-1:0] r_b;
  logic                r_v1;
  logic                r_v2;
  logic [TDC_BITS+1:0] w_pad;
  logic [TDC_BITS-1:0] w_maj;
  logic [TDC_BITS-2:0] w_edge;
  logic [POS_W-1:0]    w_first;
  logic [POS_W-1:0]    w_bin_new;
  logic [POS_W:0]      w_err_new;
  logic                w_any;
  logic                w_multi;

  logic [POS_W-1:0]    r_phase_bin;
  logic [POS_W:0]      r_phase_err;
  logic                r_err_valid;
  logic                r_edge_none;
  logic                r_edge_multi;
  logic                r_lock_det;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_HIT_W-1:0]  r_hit_cnt;
  logic [C_HIT_W-1:0]  w_hit_nxt;
  logic [C_MISS_W-1:0] r_miss_cnt;
  logic [C_MISS_W-1:0] w_miss_nxt;
  int                  w_err_int;
  logic                w_hit;

  // Pad so tap -1 reads as 1 and tap TDC_BITS reads as 0.
  assign w_pad = {1'b0, r_t1, 1'b1};

  for (genvar i = 0; i < TDC_BITS; i++) begin : g_maj
    assign w_maj[i] = (w_pad[i] & w_pad[i+1]) | (w_pad[i] & w_pad[i+2]) |
                      (w_pad[i+1] & w_pad[i+2]);
  end

  for (genvar i = 0; i < TDC_BITS - 1; i++) begin : g_edge
    assign w_edge[i] = r_b[i] & ~r_b[i+1];
  end

  // Descending scan so the lowest edge index is the one that sticks.
  always_comb begin
    w_first = '0;
    for (int i = TDC_BITS - 2; i >= 0; i--) begin
      if (w_edge[i]) w_first = POS_W'(i + 1);
    end
  end

  assign w_any     = |w_edge;
  assign w_multi   = |(w_edge & (w_edge - (TDC_BITS-1)'(1)));
  assign w_bin_new = w_any ? w_first : r_phase_bin;
  assign w_err_new = {w_bin_new[POS_W-1], w_bin_new} - {tdc_offset[POS_W-1], tdc_offset};

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= '0;
      r_v1 <= 1'b0;
      r_b  <= '0;
      r_v2 <= 1'b0;
    end else begin
      if (tdc_en) r_t1 <= sampled_tdc;
      r_v1 <= tdc_en;
      r_b  <= w_maj;
      r_v2 <= r_v1;
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_bin  <= '0;
      r_phase_err  <= '0;
      r_err_valid  <= 1'b0;
      r_edge_none  <= 1'b0;
      r_edge_multi <= 1'b0;
    end else begin
      r_err_valid <= r_v2;
      if (r_v2) begin
        r_phase_bin  <= w_bin_new;
        r_phase_err  <= w_err_new;
        r_edge_none  <= ~w_any;
        r_edge_multi <= w_multi;
      end
    end
  end

  assign w_err_int = int'($signed(r_phase_err));
  assign w_hit     = !r_edge_none && (w_err_int >= -LOCK_WIN) && (w_err_int <= LOCK_WIN);

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCK;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_lock_det <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit_cnt  <= w_hit_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_lock_det <= (w_state_nxt == ST_LOCK);
    end
  end

  // Counters only step below their terminal value, so they cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit_cnt;
    w_miss_nxt  = r_miss_cnt;
    if (r_err_valid) begin
      case (r_state)
        ST_UNLOCK: begin
          if (w_hit) begin
            w_hit_nxt   = C_HIT_W'(1);
            w_state_nxt = ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (!w_hit) begin
            w_hit_nxt   = '0;
            w_state_nxt = ST_UNLOCK;
          end else if (int'(r_hit_cnt) >= LOCK_CNT - 1) begin
            w_hit_nxt   = '0;
            w_state_nxt = ST_LOCK;
          end else begin
            w_hit_nxt = r_hit_cnt + C_HIT_W'(1);
          end
        end
        ST_LOCK: begin
          if (w_hit) begin
            w_miss_nxt = '0;
          end else if (int'(r_miss_cnt) >= UNLOCK_CNT - 1) begin
            w_miss_nxt  = '0;
            w_state_nxt = ST_UNLOCK;
          end else begin
            w_miss_nxt = r_miss_cnt + C_MISS_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCK;
          w_hit_nxt   = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  assign phase_bin  = r_phase_bin;
  assign phase_err  = r_phase_err;
  assign err_valid  = r_err_valid;
  assign edge_none  = r_edge_none;
  assign edge_multi = r_edge_multi;
  assign lock_det   = r_lock_det;

endmodule
`default_nettype wire

// File: tb/tb_tdc_thrm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_thrm_decoder
// Brief    : Directed self-checking bench for tdc_thrm_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_thrm_decoder;

  logic        ref_clk = 1'b0;
  logic        rst_n;
  logic [63:0] sampled_tdc;
  logic        tdc_en;
  logic [6:0]  tdc_offset;
  logic [6:0]  phase_bin;
  logic [7:0]  phase_err;
  logic        err_valid;
  logic        edge_none;
  logic        edge_multi;
  logic        lock_det;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] C_HIT  = 64'h0000_0000_001F_FFFF;  // bin 21
  localparam logic [63:0] C_MISS = 64'h0000_0000_00FF_FFFF;  // bin 24

  tdc_thrm_decoder #(
    .TDC_BITS(64), .POS_W(7), .LOCK_WIN(2), .LOCK_CNT(16), .UNLOCK_CNT(4)
  ) dut (
    .ref_clk    (ref_clk),
    .rst_n      (rst_n),
    .sampled_tdc(sampled_tdc),
    .tdc_en     (tdc_en),
    .tdc_offset (tdc_offset),
    .phase_bin  (phase_bin),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .edge_none  (edge_none),
    .edge_multi (edge_multi),
    .lock_det   (lock_det)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  // Present one sample for a single cycle; returns when its result is visible.
  task automatic send_one(input logic [63:0] s);
    sampled_tdc = s;
    tdc_en      = 1'b1;
    tick();
    tdc_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    tdc_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    sampled_tdc = 64'h0000_0000_0000_FFFF;
    tdc_en      = 1'b1;
    tdc_offset  = 7'd0;
    tick(); tick(); tick();
    checks++;
    if ({phase_bin, phase_err, err_valid, edge_none, edge_multi, lock_det} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bin=%0d err=%0h v=%b n=%b m=%b l=%b expected all 0",
               phase_bin, phase_err, err_valid, edge_none, edge_multi, lock_det);
    end
    rst_n = 1'b1;
    tick();
    tdc_en = 1'b0;
    tick();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++; $display("FAIL reset_early_valid: got %b expected 0", err_valid);
    end
    tick();
    checks++;
    if (err_valid !== 1'b1 || phase_bin !== 7'd16 || phase_err !== 8'd16) begin
      errors++;
      $display("FAIL reset_first_valid: got v=%b bin=%0d err=%0h expected v=1 bin=16 err=10",
               err_valid, phase_bin, phase_err);
    end
    tick();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++; $display("FAIL reset_strobe_width: got %b expected 0", err_valid);
    end
  endtask

  task automatic test_clean_edge();
    tdc_offset  = 7'd20;
    sampled_tdc = C_MISS;
    tdc_en      = 1'b1;
    tick();
    tdc_en = 1'b0;
    tick();
    checks++;
    if (err_valid !== 1'b0) begin
      errors++; $display("FAIL clean_latency: got err_valid=%b expected 0 at N+2", err_valid);
    end
    tick();
    checks++;
    if (err_valid !== 1'b1 || phase_bin !== 7'd24 || phase_err !== 8'd4 ||
        edge_none !== 1'b0 || edge_multi !== 1'b0) begin
      errors++;
      $display("FAIL clean_edge: got v=%b bin=%0d err=%0h n=%b m=%b expected v=1 bin=24 err=4 n=0 m=0",
               err_valid, phase_bin, phase_err, edge_none, edge_multi);
    end
    tick();
    checks++;
    if (err_valid !== 1'b0 || phase_bin !== 7'd24 || phase_err !== 8'd4) begin
      errors++;
      $display("FAIL clean_hold: got v=%b bin=%0d err=%0h expected v=0 bin=24 err=4",
               err_valid, phase_bin, phase_err);
    end
  endtask

  task automatic test_bubble();
    tdc_offset = 7'd20;
    send_one(64'h0000_0000_00FF_FEFF);
    checks++;
    if (phase_bin !== 7'd24 || edge_multi !== 1'b0 || edge_none !== 1'b0) begin
      errors++;
      $display("FAIL bubble_single: got bin=%0d m=%b n=%b expected bin=24 m=0 n=0",
               phase_bin, edge_multi, edge_none);
    end
    send_one(64'h0000_0000_00FF_FCFF);
    checks++;
    if (phase_bin !== 7'd8 || edge_multi !== 1'b1 || phase_err !== 8'hF4) begin
      errors++;
      $display("FAIL bubble_double: got bin=%0d m=%b err=%0h expected bin=8 m=1 err=f4",
               phase_bin, edge_multi, phase_err);
    end
  endtask

  task automatic test_multi_none();
    tdc_offset = 7'd20;
    send_one(C_MISS);
    send_one(64'h0000_FF00_0000_00FF);
    checks++;
    if (phase_bin !== 7'd8 || edge_multi !== 1'b1 || edge_none !== 1'b0 || phase_err !== 8'hF4) begin
      errors++;
      $display("FAIL multi_edge: got bin=%0d m=%b n=%b err=%0h expected bin=8 m=1 n=0 err=f4",
               phase_bin, edge_multi, edge_none, phase_err);
    end
    send_one(64'h0);
    checks++;
    if (phase_bin !== 7'd8 || edge_none !== 1'b1 || edge_multi !== 1'b0 || err_valid !== 1'b1) begin
      errors++;
      $display("FAIL none_zeros: got bin=%0d n=%b m=%b v=%b expected bin=8 n=1 m=0 v=1",
               phase_bin, edge_none, edge_multi, err_valid);
    end
    send_one('1);
    checks++;
    if (phase_bin !== 7'd8 || edge_none !== 1'b1 || edge_multi !== 1'b0) begin
      errors++;
      $display("FAIL none_ones: got bin=%0d n=%b m=%b expected bin=8 n=1 m=0",
               phase_bin, edge_none, edge_multi);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] smp [4] = '{64'h00FF, 64'hFFFF, 64'h0, 64'h00FF_FFFF};
    logic [6:0]  ebin[4] = '{7'd8, 7'd16, 7'd16, 7'd24};
    logic [7:0]  eerr[4] = '{8'hFE, 8'h06, 8'h06, 8'h0E};
    logic        enon[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    tdc_offset = 7'd10;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        sampled_tdc = smp[t];
        tdc_en      = 1'b1;
      end else begin
        tdc_en = 1'b0;
      end
      tick();
      if (t >= 2 && t < 6) begin
        checks++;
        if (err_valid !== 1'b1 || phase_bin !== ebin[t-2] || phase_err !== eerr[t-2] ||
            edge_none !== enon[t-2]) begin
          errors++;
          $display("FAIL b2b_%0d: got v=%b bin=%0d err=%0h n=%b expected v=1 bin=%0d err=%0h n=%b",
                   t - 2, err_valid, phase_bin, phase_err, edge_none, ebin[t-2], eerr[t-2], enon[t-2]);
        end
      end else if (t == 6) begin
        checks++;
        if (err_valid !== 1'b0 || phase_bin !== 7'd24) begin
          errors++;
          $display("FAIL b2b_tail: got v=%b bin=%0d expected v=0 bin=24", err_valid, phase_bin);
        end
      end
    end
  endtask

  task automatic test_lock_acquire();
    do_reset();
    tdc_offset = 7'd20;
    for (int k = 1; k <= 16; k++) begin
      send_one(C_HIT);
      if (k == 16) begin
        checks++;
        if (lock_det !== 1'b0 || err_valid !== 1'b1) begin
          errors++;
          $display("FAIL lock_early: got lock=%b v=%b expected lock=0 v=1 on 16th strobe",
                   lock_det, err_valid);
        end
      end
      tick();
      checks++;
      if (lock_det !== (k == 16)) begin
        errors++;
        $display("FAIL lock_acq_%0d: got %b expected %b", k, lock_det, (k == 16));
      end
    end
  endtask

  task automatic test_lock_restart();
    do_reset();
    tdc_offset = 7'd20;
    for (int k = 1; k <= 9; k++) begin
      send_one(C_HIT);
      tick();
    end
    send_one(C_MISS);
    tick();
    for (int k = 1; k <= 16; k++) begin
      send_one(C_HIT);
      tick();
      checks++;
      if (lock_det !== (k == 16)) begin
        errors++;
        $display("FAIL lock_restart_%0d: got %b expected %b", k, lock_det, (k == 16));
      end
    end
  endtask

  task automatic test_unlock_hyst();
    logic [63:0] seq[7] = '{64'h0, C_MISS, 64'hFFFF, C_HIT, C_MISS, 64'h0, 64'hFFFF};
    for (int k = 0; k < 7; k++) begin
      send_one(seq[k]);
      tick();
      checks++;
      if (lock_det !== 1'b1) begin
        errors++; $display("FAIL hyst_hold_%0d: got %b expected 1", k, lock_det);
      end
    end
    send_one(C_MISS);
    checks++;
    if (lock_det !== 1'b1) begin
      errors++; $display("FAIL hyst_4th_same: got %b expected 1", lock_det);
    end
    tick();
    checks++;
    if (lock_det !== 1'b0) begin
      errors++; $display("FAIL hyst_drop: got %b expected 0", lock_det);
    end
  endtask

  task automatic test_reset_mid();
    tdc_offset  = 7'd20;
    sampled_tdc = C_HIT;
    tdc_en      = 1'b1;
    tick();
    tick();
    tdc_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({phase_bin, phase_err, err_valid, edge_none, edge_multi, lock_det} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got bin=%0d err=%0h v=%b n=%b m=%b l=%b expected all 0",
               phase_bin, phase_err, err_valid, edge_none, edge_multi, lock_det);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (err_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_stale_%0d: got %b expected 0", k, err_valid);
      end
    end
    send_one(C_HIT);
    checks++;
    if (err_valid !== 1'b1 || phase_bin !== 7'd21 || phase_err !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_resume: got v=%b bin=%0d err=%0h expected v=1 bin=21 err=1",
               err_valid, phase_bin, phase_err);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    tdc_en      = 1'b0;
    sampled_tdc = '0;
    tdc_offset  = '0;
    test_reset();
    test_clean_edge();
    test_bubble();
    test_multi_none();
    test_back_to_back();
    test_lock_acquire();
    test_unlock_hyst();
    test_lock_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
